// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for the EX stage (func_mux div_out).
// Optional macro DIV_SPECIAL_FAST_EN lets divide-by-zero and signed overflow skip CALC.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       div_type,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

`ifdef DIV_SPECIAL_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, quo_q, final_q, result_q;
  logic [1:0]       type_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_q;

  // div_type[0]=0 selects the signed operations, div_type[1]=1 selects remainder.
  function automatic logic is_special(input logic [1:0] t, input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
    return (y == '0) ||
           (!t[0] && x == {1'b1, {(WIDTH-1){1'b0}}} && y == '1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [1:0] t, input logic [WIDTH-1:0] x);
    return (!t[0] && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] fix_up(input logic [1:0] t, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] qm,
                                              input logic [WIDTH-1:0] rm);
    logic [WIDTH-1:0] q, r;
    if (y == '0) begin
      q = '1;
      r = x;
    end else if (is_special(t, x, y)) begin
      q = {1'b1, {(WIDTH-1){1'b0}}};
      r = '0;
    end else begin
      q = (!t[0] && (x[WIDTH-1] ^ y[WIDTH-1])) ? -qm : qm;
      r = (!t[0] && x[WIDTH-1]) ? -rm : rm;
    end
    return t[1] ? r : q;
  endfunction

  // One restoring step: the dividend magnitude shifts out of quo_q into the remainder.
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_shift, rem_nxt;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo_nxt;
  logic             take;

  always_comb begin
    b_abs     = mag(type_q, b_q);
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {2'b00, b_abs};
    take      = ~diff[WIDTH+1];
    rem_nxt   = take ? diff[WIDTH:0] : rem_shift;
    quo_nxt   = {quo_q[WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush)
              state_nxt = (FAST_EN && is_special(div_type, a, b)) ? DONE : CALC;
      CALC: if (flush)          state_nxt = IDLE;
            else if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      type_q   <= '0;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      final_q  <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          a_q    <= a;
          b_q    <= b;
          type_q <= div_type;
          cnt    <= CW'(WIDTH-1);
          rem_q  <= '0;
          quo_q  <= mag(div_type, a);
          if (FAST_EN && is_special(div_type, a, b))
            final_q <= fix_up(div_type, a, b, '0, '0);
        end
        CALC: if (!flush) begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == '0)
            final_q <= fix_up(type_q, a_q, b_q, quo_nxt, rem_nxt[WIDTH-1:0]);
        end
        DONE: if (!flush) result_q <= final_q;
        default: ;
      endcase
    end
  end

  // A flush in DONE must hide the new value as well as the pulse.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !flush;
  assign result    = done ? final_q : result_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases, flush/reset/ignored-start
// timelines and random operations checked against a behavioural model.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   div_type;
  logic [W-1:0] a, b, result;
  logic         busy, done;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;
  int           n_checks = 0;
  int           n_fail = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .div_type(div_type), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic special(input logic [1:0] t, input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) || (!t[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  function automatic int done_cycle(input logic [1:0] t, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DIV_SPECIAL_FAST_EN
    return special(t, x, y) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] t, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy, sr;
    sx = x;
    sy = y;
    if (y == 0) return t[1] ? x : 32'hFFFF_FFFF;
    if (!t[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return t[1] ? 32'h0 : 32'h8000_0000;
    if (!t[0]) begin
      sr = t[1] ? (sx % sy) : (sx / sy);
      return sr;
    end
    return t[1] ? (x % y) : (x / y);
  endfunction

  // driver: start held for one cycle (cycle 0); operand pins then scrambled
  task automatic start_op(input logic [1:0] t, input logic [W-1:0] x, input logic [W-1:0] y);
    div_type = t;
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    div_type = 2'($urandom_range(0, 3));
  endtask

  // scoreboard: pop on the done pulse, check its cycle, busy span and held result
  task automatic wait_done(input string tag, input int cyc0, input int exp_cyc);
    int cyc = cyc0;
    int busy_bad = 0;
    bit seen = 0;
    logic [W-1:0] exp;
    while (!seen && cyc < 120) begin
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) seen = 1;
      else begin
        step();
        cyc++;
      end
    end
    if (seen) begin
      exp = exp_q.pop_front();
      check(tag, result, exp);
      check({tag, "_cycle"}, W'(cyc), W'(exp_cyc));
      check({tag, "_busy"}, W'(busy_bad), '0);
      last_res = exp;
      step();
      check({tag, "_idle"}, {30'd0, busy, done}, '0);
      check({tag, "_held"}, result, exp);
    end else begin
      check({tag, "_timeout"}, '0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] t, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    start_op(t, x, y);
    wait_done(tag, 1, done_cycle(t, x, y));
  endtask

  initial begin
    int dbad;
    logic [1:0] t;
    logic [W-1:0] x, y;
    rst = 1'b1; start = 1'b0; flush = 1'b0; div_type = 2'd0; a = '0; b = '0;
    last_res = '0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_busy", {31'd0, busy}, '0);
    check("reset_done", {31'd0, done}, '0);
    check("reset_result", result, '0);

    run_op("ss_div_100_7", 2'b00, 32'd100, 32'd7, 32'd14);
    run_op("ss_rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("ss_div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("uu_div_big_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    run_op("uu_div_by0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("uu_rem_by0", 2'b11, 32'd5, 32'd0, 32'd5);
    run_op("ss_div_neg_by0", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_op("ss_rem_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_op("ss_div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("ss_rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("uu_div_ovf_pat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // flush mid-calc, then restart in cycle 12
    start_op(2'b00, 32'd100, 32'd7);
    dbad = 0;
    for (int c = 1; c < 10; c++) begin
      if (done !== 1'b0) dbad++;
      step();
    end
    flush = 1'b1;
    if (done !== 1'b0) dbad++;
    step();
    flush = 1'b0;
    if (done !== 1'b0) dbad++;
    check("flush_busy", {31'd0, busy}, '0);
    check("flush_no_done", W'(dbad), '0);
    check("flush_result_kept", result, last_res);
    step();
    exp_q.push_back(32'd3);
    start_op(2'b00, 32'd9, 32'd3);
    wait_done("flush_restart", 13, 45);

    // start while busy is ignored
    exp_q.push_back(32'd14);
    start_op(2'b00, 32'd100, 32'd7);
    repeat (4) step();
    start = 1'b1; a = 32'd1; b = 32'd1; div_type = 2'b01;
    step();
    start = 1'b0;
    wait_done("ignored_start", 6, 33);

    // reset in cycle 20
    start_op(2'b00, 32'd100, 32'd7);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", {30'd0, busy, done}, '0);
    check("midrst_result", result, '0);
    last_res = '0;
    step();
    check("midrst_stay_idle", {30'd0, busy, done}, '0);

    // flush in DONE hides the pulse and keeps the old result
    run_op("uu_div_50_5", 2'b01, 32'd50, 32'd5, 32'd10);
    start_op(2'b01, 32'd20, 32'd3);
    repeat (32) step();
    check("done_pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("done_flush_pulse", {31'd0, done}, '0);
    check("done_flush_result", result, last_res);
    step();
    flush = 1'b0;
    check("done_flush_idle", {31'd0, busy}, '0);
    check("done_flush_kept", result, last_res);

    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; a = 32'd40; b = 32'd4; div_type = 2'b01;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {31'd0, busy}, '0);
    step();
    check("flush_start_kept", result, last_res);

    repeat (16) begin
      t = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        3: y = -32'($urandom_range(1, 15));
        default: y = 32'($urandom);
      endcase
      run_op("random", t, x, y, model(t, x, y));
    end

    check("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 div_type  input  2  operation select: 00 ss_div, 01 uu_div, 10 ss_rem, 11 uu_rem.
REQ-006 a  input  WIDTH  dividend; sampled with start.
REQ-007 b  input  WIDTH  divisor; sampled with start.
REQ-008 flush  input  1  abort the in-flight operation (branch mispredict or interrupt).
REQ-009 busy  output  1  high from the cycle after start is accepted until done or abort.
REQ-010 done  output  1  single-cycle pulse when result is valid.
REQ-011 result  output  WIDTH  quotient or remainder per div_type; held stable until the next accepted start.

Function
REQ-012 The block SHALL be the EX-stage divider whose result is selected by func_mux value div_out (3'b100).
REQ-013 The FSM SHALL have states IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: start=1 and flush=0 -> latch a, b, and div_type; take operand magnitudes for signed types; enter CALC with counter=WIDTH-1.
REQ-015 CALC: the FSM SHALL perform one restoring radix-2 iteration per cycle (shift remainder left 1, subtract |b|, set quotient bit if result is non-negative, restore otherwise) and decrement the counter.
REQ-016 CALC with counter=0 -> DONE; DONE -> IDLE unconditionally next cycle.
REQ-017 done=1 only in DONE; with start sampled in cycle 0, a normal operation asserts done in cycle WIDTH+1 (cycle 33).
REQ-018 Signed fix-up: quotient negated if sign(a) XOR sign(b); remainder takes sign(a); applied when entering DONE.
REQ-019 b=0: quotient=all ones (0xFFFFFFFF), remainder=a, for both signed and unsigned types.
REQ-020 Signed overflow (a=0x80000000, b=0xFFFFFFFF, signed type): quotient=0x80000000, remainder=0.
REQ-021 busy=1 in CALC and DONE, and 0 in IDLE; start while busy=1 SHALL be ignored, and latched operands SHALL stay unchanged.
REQ-022 flush=1 in CALC or DONE -> IDLE next cycle, done stays 0 (a flush in DONE suppresses the pulse), and result keeps its prior value.
REQ-023 flush=1 and start=1 together in IDLE: flush wins and the operation is not accepted.
REQ-024 Internal datapath SHALL be WIDTH+1 bits for the partial remainder; no truncation of intermediate subtraction.

Reset
REQ-025 rst=1 in any state SHALL force IDLE next edge, including mid-CALC, and discard the operation.
REQ-026 Reset values: busy=0, done=0, result=0, counter=0, latched operands=0.

Configuration
REQ-027 Macro DIV_SPECIAL_FAST_EN defined: the b=0 and signed-overflow cases SHALL bypass CALC (IDLE -> DONE), with done in cycle 1.
REQ-028 Macro DIV_SPECIAL_FAST_EN undefined: the special cases SHALL take the full CALC path with done in cycle 33; results are identical to those in REQ-019 and REQ-020.

Verification
REQ-029 ss_div a=100, b=7 -> result=14, done exactly in cycle 33, busy cycles 1-33.
REQ-030 ss_rem a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFF (-1); ss_div on the same operands -> 0xFFFFFFFD (-3); uu_div 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-031 uu_div a=5, b=0 -> 0xFFFFFFFF, and uu_rem on the same operands -> 5; done in cycle 1 with DIV_SPECIAL_FAST_EN and in cycle 33 without it.
REQ-032 ss_div a=0x80000000, b=0xFFFFFFFF -> 0x80000000, and ss_rem on the same operands -> 0.
REQ-033 Start a=100, b=7; flush in cycle 10 -> busy=0 from cycle 11, no done pulse; result keeps its prior value; new start a=9, b=3 in cycle 12 -> result=3 in cycle 45.
REQ-034 Start a=100, b=7; start=1 with a=1, b=1 in cycle 5 -> ignored, and the result is still 14; rst=1 in cycle 20 -> busy=0, done=0, result=0 from cycle 21.
